// File: rtl/cpu_clken_gate_if.sv
// Bus-clock interface between the pause block, the E/Q clock generator and the CPU core.
// The slave modport is the clock generator's view; the master modport is the requester/consumer side.
interface cpu_clken_gate_if #(
    parameter int unsigned CNTW = 16
);
    logic            pause_cpu;
    logic            cpu_e;
    logic            cpu_q;
    logic            e_rise_en;
    logic            e_fall_en;
    logic            q_rise_en;
    logic            q_fall_en;
    logic            paused;
    logic [CNTW-1:0] e_cycles;

    modport master (
        output pause_cpu,
        input  cpu_e, cpu_q, e_rise_en, e_fall_en, q_rise_en, q_fall_en, paused, e_cycles
    );

    modport slave (
        input  pause_cpu,
        output cpu_e, cpu_q, e_rise_en, e_fall_en, q_rise_en, q_fall_en, paused, e_cycles
    );
endinterface

// File: rtl/cpu_clken_gate.sv
// 6809-style quadrature E/Q clock generator with edge enables.
// A pause request is honoured only at the end of a bus cycle, so the CPU never stops mid-cycle.
module cpu_clken_gate #(
    parameter int unsigned DIV  = 3,
    parameter int unsigned CNTW = 16
) (
    input  logic               clk_sys,
    input  logic               reset,
    cpu_clken_gate_if.slave    bus
);
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {ST_RUN, ST_STOPPING, ST_HALTED} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [1:0]      phase_q, phase_d;
    logic            cpu_e_q, cpu_e_d;
    logic            cpu_q_q, cpu_q_d;
    logic            e_rise_q, e_rise_d;
    logic            e_fall_q, e_fall_d;
    logic            q_rise_q, q_rise_d;
    logic            q_fall_q, q_fall_d;
    logic            paused_q, paused_d;
    logic [CNTW-1:0] e_cycles_q, e_cycles_d;
    logic            wrap;
    logic            boundary;

    // Next-state: phase advance, edge pulses and pause handshake
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        phase_d    = phase_q;
        paused_d   = paused_q;
        e_cycles_d = e_cycles_q;
        e_rise_d   = 1'b0;
        e_fall_d   = 1'b0;
        q_rise_d   = 1'b0;
        q_fall_d   = 1'b0;
        wrap       = (div_cnt_q == DW'(DIV - 1));
        boundary   = wrap && (phase_q == 2'd3);

        unique case (state_q)
            ST_RUN, ST_STOPPING: begin
                if (wrap) begin
                    div_cnt_d = '0;
                    phase_d   = phase_q + 2'd1;
                    case (phase_q)
                        2'd0: q_rise_d = 1'b1;
                        2'd1: e_rise_d = 1'b1;
                        2'd2: q_fall_d = 1'b1;
                        2'd3: e_fall_d = 1'b1;
                        default: ;
                    endcase
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
                if (boundary) begin
                    e_cycles_d = e_cycles_q + CNTW'(1);
                end
                // A pending stop is committed at the bus boundary even if the request just dropped
                if (boundary && ((state_q == ST_STOPPING) || bus.pause_cpu)) begin
                    state_d  = ST_HALTED;
                    paused_d = 1'b1;
                end else if (bus.pause_cpu) begin
                    state_d = ST_STOPPING;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                div_cnt_d = '0;
                phase_d   = 2'd0;
                if (!bus.pause_cpu) begin
                    state_d  = ST_RUN;
                    paused_d = 1'b0;
                end
            end
            default: state_d = ST_RUN;
        endcase

        cpu_e_d = phase_d[1];
        cpu_q_d = phase_d[1] ^ phase_d[0];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_RUN;
            div_cnt_q  <= '0;
            phase_q    <= 2'd0;
            cpu_e_q    <= 1'b0;
            cpu_q_q    <= 1'b0;
            e_rise_q   <= 1'b0;
            e_fall_q   <= 1'b0;
            q_rise_q   <= 1'b0;
            q_fall_q   <= 1'b0;
            paused_q   <= 1'b0;
            e_cycles_q <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            phase_q    <= phase_d;
            cpu_e_q    <= cpu_e_d;
            cpu_q_q    <= cpu_q_d;
            e_rise_q   <= e_rise_d;
            e_fall_q   <= e_fall_d;
            q_rise_q   <= q_rise_d;
            q_fall_q   <= q_fall_d;
            paused_q   <= paused_d;
            e_cycles_q <= e_cycles_d;
        end
    end

    assign bus.cpu_e     = cpu_e_q;
    assign bus.cpu_q     = cpu_q_q;
    assign bus.e_rise_en = e_rise_q;
    assign bus.e_fall_en = e_fall_q;
    assign bus.q_rise_en = q_rise_q;
    assign bus.q_fall_en = q_fall_q;
    assign bus.paused    = paused_q;
    assign bus.e_cycles  = e_cycles_q;
endmodule
